// File: rtl/ctrl_seq_if.sv
// rtl/ctrl_seq_if.sv - sequencer bus: memory handshakes, ALU flags, datapath selects
interface ctrl_seq_if #(
    parameter int ALUOP_W = 4
);
    logic [31:0]        instr;
    logic               ihit;
    logic               dhit;
    logic               zero;
    logic               negative;
    logic               overflow;
    logic               imemREN;
    logic               dmemREN;
    logic               dmemWEN;
    logic               PCEn;
    logic [1:0]         PCSrc;
    logic               RegWEN;
    logic [1:0]         RegDest;
    logic [1:0]         MemtoReg;
    logic               ExtOp;
    logic               ALUSrc;
    logic [ALUOP_W-1:0] ALUOP;
    logic [31:0]        ir;
    logic               halt;
    logic               timeout;

    modport master (
        input  instr, ihit, dhit, zero, negative, overflow,
        output imemREN, dmemREN, dmemWEN, PCEn, PCSrc, RegWEN, RegDest,
               MemtoReg, ExtOp, ALUSrc, ALUOP, ir, halt, timeout
    );

    modport slave (
        output instr, ihit, dhit, zero, negative, overflow,
        input  imemREN, dmemREN, dmemWEN, PCEn, PCSrc, RegWEN, RegDest,
               MemtoReg, ExtOp, ALUSrc, ALUOP, ir, halt, timeout
    );
endinterface

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - multi-cycle FETCH/EXEC/MEM/WB sequencer with memory-wait watchdog
// Define OVF_TRAP_EN to halt on signed overflow of ADD/SUB/ADDI instead of writing back.
module ctrl_seq #(
    parameter int WAIT_MAX = 15,
    parameter int ALUOP_W  = 4
) (
    input  logic       CLK,
    input  logic       nRST,
    ctrl_seq_if.master bus
);
    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [ALUOP_W-1:0] ALU_SLL  = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SRL  = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(6);
    localparam logic [ALUOP_W-1:0] ALU_NOR  = ALUOP_W'(7);
    localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(8);
    localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(9);

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t             r_state;
    logic [31:0]        r_ir;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_halt, r_timeout;
    logic               r_regwen, r_pcen;
    logic [1:0]         r_pcsrc, r_regdest, r_memtoreg;
    logic               r_extop, r_alusrc;
    logic [ALUOP_W-1:0] r_aluop;
    logic               r_dren, r_dwen;
    logic               r_wr, r_lw, r_sw, r_beq, r_bne, r_j, r_jal, r_jr, r_hlt, r_ovf_op;

    logic [5:0]         w_op, w_funct;
    logic               w_wr, w_lw, w_sw, w_beq, w_bne, w_j, w_jal, w_jr, w_hlt, w_ovf_op;
    logic [1:0]         w_regdest, w_memtoreg, w_pcsrc_exec;
    logic               w_extop, w_alusrc;
    logic [ALUOP_W-1:0] w_aluop;
    logic               w_cnt_last, w_take, w_ovf_trap;
    logic               w_unused;

    assign w_op    = bus.instr[31:26];
    assign w_funct = bus.instr[5:0];

    // Decode the word being fetched; results are latched alongside ir so they stay
    // stable for the whole instruction. Unlisted opcodes/functs decode to a NOP.
    always_comb begin
        w_wr = 1'b0; w_lw = 1'b0; w_sw = 1'b0; w_beq = 1'b0; w_bne = 1'b0;
        w_j = 1'b0; w_jal = 1'b0; w_jr = 1'b0; w_hlt = 1'b0; w_ovf_op = 1'b0;
        w_regdest = 2'd0; w_memtoreg = 2'd0; w_extop = 1'b0; w_alusrc = 1'b0;
        w_aluop = ALU_SLL;
        case (w_op)
            OP_RTYPE: begin
                w_wr      = 1'b1;
                w_regdest = 2'd1;
                case (w_funct)
                    F_SLL:  w_aluop = ALU_SLL;
                    F_SRL:  w_aluop = ALU_SRL;
                    F_JR:   begin w_wr = 1'b0; w_jr = 1'b1; w_regdest = 2'd0; end
                    F_ADD:  begin w_aluop = ALU_ADD; w_ovf_op = 1'b1; end
                    F_ADDU: w_aluop = ALU_ADD;
                    F_SUB:  begin w_aluop = ALU_SUB; w_ovf_op = 1'b1; end
                    F_SUBU: w_aluop = ALU_SUB;
                    F_AND:  w_aluop = ALU_AND;
                    F_OR:   w_aluop = ALU_OR;
                    F_XOR:  w_aluop = ALU_XOR;
                    F_NOR:  w_aluop = ALU_NOR;
                    F_SLT:  w_aluop = ALU_SLT;
                    F_SLTU: w_aluop = ALU_SLTU;
                    default: begin w_wr = 1'b0; w_regdest = 2'd0; end
                endcase
            end
            OP_J:     w_j = 1'b1;
            OP_JAL:   begin w_jal = 1'b1; w_wr = 1'b1; w_regdest = 2'd2; w_memtoreg = 2'd2; end
            OP_BEQ:   begin w_beq = 1'b1; w_extop = 1'b1; w_aluop = ALU_SUB; end
            OP_BNE:   begin w_bne = 1'b1; w_extop = 1'b1; w_aluop = ALU_SUB; end
            OP_ADDI:  begin w_wr = 1'b1; w_extop = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_ADD; w_ovf_op = 1'b1; end
            OP_ADDIU: begin w_wr = 1'b1; w_extop = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_ADD; end
            OP_SLTI:  begin w_wr = 1'b1; w_extop = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_SLT; end
            OP_SLTIU: begin w_wr = 1'b1; w_extop = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_SLTU; end
            OP_ANDI:  begin w_wr = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_AND; end
            OP_ORI:   begin w_wr = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_OR; end
            OP_XORI:  begin w_wr = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_XOR; end
            OP_LUI:   begin w_wr = 1'b1; w_alusrc = 1'b1; w_memtoreg = 2'd3; end
            OP_LW:    begin w_lw = 1'b1; w_wr = 1'b1; w_extop = 1'b1; w_alusrc = 1'b1; w_memtoreg = 2'd1; w_aluop = ALU_ADD; end
            OP_SW:    begin w_sw = 1'b1; w_extop = 1'b1; w_alusrc = 1'b1; w_aluop = ALU_ADD; end
            OP_HALT:  w_hlt = 1'b1;
            default:  w_wr = 1'b0;
        endcase
    end

    // Timeout fires on the cycle the count would reach WAIT_MAX; a hit that cycle still wins.
    assign w_cnt_last = (r_cnt == CNT_W'(WAIT_MAX - 1));
    assign w_take     = (r_beq & bus.zero) | (r_bne & ~bus.zero);

    always_comb begin
        w_pcsrc_exec = 2'd0;
        if (r_jr)               w_pcsrc_exec = 2'd3;
        else if (r_j || r_jal)  w_pcsrc_exec = 2'd2;
        else if (w_take)        w_pcsrc_exec = 2'd1;
    end

`ifdef OVF_TRAP_EN
    assign w_ovf_trap = r_ovf_op & bus.overflow;
`else
    assign w_ovf_trap = 1'b0;
`endif

    assign w_unused = bus.negative ^ bus.overflow;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_FETCH;   r_ir <= 32'd0;       r_cnt <= '0;
            r_halt <= 1'b0;       r_timeout <= 1'b0;
            r_regwen <= 1'b0;     r_pcen <= 1'b0;      r_pcsrc <= 2'd0;
            r_regdest <= 2'd0;    r_memtoreg <= 2'd0;  r_extop <= 1'b0;
            r_alusrc <= 1'b0;     r_aluop <= '0;       r_dren <= 1'b0;   r_dwen <= 1'b0;
            r_wr <= 1'b0;  r_lw <= 1'b0;  r_sw <= 1'b0;  r_beq <= 1'b0;  r_bne <= 1'b0;
            r_j <= 1'b0;   r_jal <= 1'b0; r_jr <= 1'b0;  r_hlt <= 1'b0;  r_ovf_op <= 1'b0;
        end else begin
            r_regwen <= 1'b0;
            r_pcen   <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (bus.ihit) begin
                        r_ir <= bus.instr;
                        r_regdest <= w_regdest; r_memtoreg <= w_memtoreg;
                        r_extop <= w_extop;     r_alusrc <= w_alusrc;   r_aluop <= w_aluop;
                        r_wr <= w_wr;   r_lw <= w_lw;   r_sw <= w_sw;   r_beq <= w_beq;
                        r_bne <= w_bne; r_j <= w_j;     r_jal <= w_jal; r_jr <= w_jr;
                        r_hlt <= w_hlt; r_ovf_op <= w_ovf_op;
                        r_state <= S_EXEC;
                    end else if (w_cnt_last) begin
                        r_halt    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (r_hlt || w_ovf_trap) begin
                        r_halt  <= 1'b1;
                        r_state <= S_HALT;
                    end else if (r_lw || r_sw) begin
                        r_cnt   <= '0;
                        r_dren  <= r_lw;
                        r_dwen  <= r_sw;
                        r_state <= S_MEM;
                    end else begin
                        r_pcen   <= 1'b1;
                        r_regwen <= r_wr;
                        r_pcsrc  <= w_pcsrc_exec;
                        r_state  <= S_WB;
                    end
                end
                S_MEM: begin
                    if (bus.dhit) begin
                        r_dren   <= 1'b0;
                        r_dwen   <= 1'b0;
                        r_pcen   <= 1'b1;
                        r_regwen <= r_wr;
                        r_pcsrc  <= 2'd0;
                        r_state  <= S_WB;
                    end else if (w_cnt_last) begin
                        r_dren    <= 1'b0;
                        r_dwen    <= 1'b0;
                        r_halt    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_state   <= S_HALT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WB: begin
                    r_cnt   <= '0;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Gated by nRST so the request is low while reset is held yet rises right at release.
    assign bus.imemREN  = nRST & (r_state == S_FETCH);
    assign bus.dmemREN  = r_dren;
    assign bus.dmemWEN  = r_dwen;
    assign bus.PCEn     = r_pcen;
    assign bus.PCSrc    = r_pcsrc;
    assign bus.RegWEN   = r_regwen;
    assign bus.RegDest  = r_regdest;
    assign bus.MemtoReg = r_memtoreg;
    assign bus.ExtOp    = r_extop;
    assign bus.ALUSrc   = r_alusrc;
    assign bus.ALUOP    = r_aluop;
    assign bus.ir       = r_ir;
    assign bus.halt     = r_halt;
    assign bus.timeout  = r_timeout;
endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - scoreboard bench for ctrl_seq sequencing, watchdog, halt and reset
module tb_ctrl_seq;
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    ctrl_seq_if #(.ALUOP_W(4)) bus();
    ctrl_seq #(.WAIT_MAX(15), .ALUOP_W(4)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       nm;
        logic [31:0] ins;
        int          iwait;
        int          dwait;
        logic        z;
        logic        regwen;
        logic [1:0]  pcsrc;
        logic [1:0]  mtr;
        logic [1:0]  rdst;
        logic        chk_sel;
        logic        ext;
        logic        alusrc;
        int          cycles;
        int          dren;
        int          dwen;
    } exp_t;

    exp_t sb_q[$];

    int          o_cycles, o_fetch, o_dren, o_dwen, o_regwen_n;
    logic        o_wb, o_halt, o_regwen, o_ext, o_alusrc, o_first_pcen, o_first_regwen;
    logic [1:0]  o_pcsrc, o_mtr, o_rdst;
    logic [31:0] o_ir;

    function automatic exp_t mk(string nm, logic [31:0] ins, int iw, int dw, logic z,
                                logic rw, logic [1:0] pc, logic [1:0] mtr, logic [1:0] rd,
                                logic cs, logic ext, logic src, int cyc, int dr, int dwn);
        exp_t e;
        e.nm = nm; e.ins = ins; e.iwait = iw; e.dwait = dw; e.z = z;
        e.regwen = rw; e.pcsrc = pc; e.mtr = mtr; e.rdst = rd;
        e.chk_sel = cs; e.ext = ext; e.alusrc = src;
        e.cycles = cyc; e.dren = dr; e.dwen = dwn;
        return e;
    endfunction

    // Plays imem/dmem for one instruction starting at a negedge in FETCH; stops after WB or halt.
    task automatic drive_instr(input logic [31:0] ins, input int iwait, input int dwait,
                               input logic z, input logic ov);
        int   dc;
        logic hit_prev;
        logic done;
        dc = 0; hit_prev = 1'b0; done = 1'b0;
        o_cycles = 0; o_fetch = 0; o_dren = 0; o_dwen = 0; o_regwen_n = 0;
        o_wb = 1'b0; o_halt = 1'b0; o_regwen = 1'b0;
        o_first_pcen = bus.PCEn; o_first_regwen = bus.RegWEN;
        bus.zero = z; bus.overflow = ov;
        while (!done && o_cycles < 64) begin
            o_cycles++;
            bus.ihit = 1'b0; bus.dhit = 1'b0; bus.instr = 32'hDEAD_BEEF;
            if (hit_prev) begin o_ext = bus.ExtOp; o_alusrc = bus.ALUSrc; end
            hit_prev = 1'b0;
            if (bus.RegWEN) o_regwen_n++;
            if (bus.imemREN) begin
                if (o_fetch == iwait) begin bus.ihit = 1'b1; bus.instr = ins; hit_prev = 1'b1; end
                o_fetch++;
            end
            if (bus.dmemREN) o_dren++;
            if (bus.dmemWEN) o_dwen++;
            if (bus.dmemREN || bus.dmemWEN) begin
                if (dc == dwait) bus.dhit = 1'b1;
                dc++;
            end
            if (bus.PCEn) begin
                o_wb = 1'b1; o_regwen = bus.RegWEN; o_pcsrc = bus.PCSrc;
                o_mtr = bus.MemtoReg; o_rdst = bus.RegDest; o_ir = bus.ir; done = 1'b1;
            end
            if (bus.halt) begin o_halt = 1'b1; o_ir = bus.ir; done = 1'b1; end
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        bus.ihit = 1'b0; bus.dhit = 1'b0; bus.zero = 1'b0; bus.overflow = 1'b0;
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        bus.instr = 32'h0; bus.ihit = 1'b0; bus.dhit = 1'b0;
        bus.zero = 1'b0; bus.negative = 1'b0; bus.overflow = 1'b0;
        nRST = 1'b0;
        @(negedge CLK);
        #1;
        total++;
        if ({bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.PCEn, bus.RegWEN} !== 5'b0) begin
            bad++; $display("FAIL reset_enables got=%b want=00000",
                {bus.imemREN, bus.dmemREN, bus.dmemWEN, bus.PCEn, bus.RegWEN});
        end
        total++;
        if ({bus.PCSrc, bus.RegDest, bus.MemtoReg, bus.ExtOp, bus.ALUSrc, bus.ALUOP} !== 12'b0) begin
            bad++; $display("FAIL reset_selects got=%b want=0",
                {bus.PCSrc, bus.RegDest, bus.MemtoReg, bus.ExtOp, bus.ALUSrc, bus.ALUOP});
        end
        total++;
        if ({bus.halt, bus.timeout, bus.ir} !== 34'b0) begin
            bad++; $display("FAIL reset_state halt=%b timeout=%b ir=%h want 0", bus.halt, bus.timeout, bus.ir);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        total++;
        if (bus.imemREN !== 1'b1) begin bad++; $display("FAIL reset_release imemREN got=%b want=1", bus.imemREN); end
    endtask

    task automatic test_decode_table();
        exp_t tbl[$];
        exp_t e;
        tbl.push_back(mk("addiu",    32'h2402_0005, 0, 0, 1'b0, 1, 0, 0, 0, 1, 1, 1, 3, 0, 0));
        tbl.push_back(mk("add_wait", 32'h0022_1820, 1, 0, 1'b0, 1, 0, 0, 1, 0, 0, 0, 4, 0, 0));
        tbl.push_back(mk("lw_wait3", 32'h8C22_0004, 0, 3, 1'b0, 1, 0, 1, 0, 1, 1, 1, 7, 4, 0));
        tbl.push_back(mk("sw",       32'hAC22_0004, 2, 0, 1'b0, 0, 0, 0, 0, 1, 1, 1, 6, 0, 1));
        tbl.push_back(mk("beq_z1",   32'h1022_0003, 0, 0, 1'b1, 0, 1, 0, 0, 1, 1, 0, 3, 0, 0));
        tbl.push_back(mk("bne_z1",   32'h1422_0003, 0, 0, 1'b1, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0));
        tbl.push_back(mk("bne_z0",   32'h1422_0003, 0, 0, 1'b0, 0, 1, 0, 0, 1, 1, 0, 3, 0, 0));
        tbl.push_back(mk("j",        32'h0800_0010, 0, 0, 1'b0, 0, 2, 0, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk("jal",      32'h0C00_0010, 0, 0, 1'b0, 1, 2, 2, 2, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk("jr",       32'h03E0_0008, 0, 0, 1'b0, 0, 3, 0, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk("lui",      32'h3C01_1234, 0, 0, 1'b0, 1, 0, 3, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk("andi",     32'h3022_000F, 0, 0, 1'b0, 1, 0, 0, 0, 1, 0, 1, 3, 0, 0));
        tbl.push_back(mk("slti",     32'h2822_0005, 2, 0, 1'b0, 1, 0, 0, 0, 1, 1, 1, 5, 0, 0));
        tbl.push_back(mk("bad_op",   32'h7C00_0000, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk("bad_fn",   32'h0000_003F, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0));
        foreach (tbl[i]) begin
            sb_q.push_back(tbl[i]);
            drive_instr(tbl[i].ins, tbl[i].iwait, tbl[i].dwait, tbl[i].z, 1'b0);
            e = sb_q.pop_front();
            total++;
            if (o_wb !== 1'b1) begin bad++; $display("FAIL %s wb_reached got=%b want=1", e.nm, o_wb); end
            total++;
            if (o_cycles !== e.cycles) begin bad++; $display("FAIL %s cycles got=%0d want=%0d", e.nm, o_cycles, e.cycles); end
            total++;
            if (o_regwen !== e.regwen) begin bad++; $display("FAIL %s RegWEN got=%b want=%b", e.nm, o_regwen, e.regwen); end
            total++;
            if (o_pcsrc !== e.pcsrc) begin bad++; $display("FAIL %s PCSrc got=%0d want=%0d", e.nm, o_pcsrc, e.pcsrc); end
            total++;
            if (o_ir !== e.ins) begin bad++; $display("FAIL %s ir got=%h want=%h", e.nm, o_ir, e.ins); end
            total++;
            if (o_dren !== e.dren || o_dwen !== e.dwen) begin
                bad++; $display("FAIL %s dmem_cycles got=%0d/%0d want=%0d/%0d", e.nm, o_dren, o_dwen, e.dren, e.dwen);
            end
            if (e.regwen) begin
                total++;
                if (o_mtr !== e.mtr || o_rdst !== e.rdst) begin
                    bad++; $display("FAIL %s MemtoReg/RegDest got=%0d/%0d want=%0d/%0d", e.nm, o_mtr, o_rdst, e.mtr, e.rdst);
                end
            end
            if (e.chk_sel) begin
                total++;
                if (o_ext !== e.ext || o_alusrc !== e.alusrc) begin
                    bad++; $display("FAIL %s ExtOp/ALUSrc got=%b/%b want=%b/%b", e.nm, o_ext, o_alusrc, e.ext, e.alusrc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [31:0] seq_ins [6] = '{32'h2402_0005, 32'h8C22_0004, 32'h1022_0003,
                                     32'h0C00_0010, 32'h0022_1820, 32'h7C00_0000};
        logic        seq_rw  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        int          seq_cyc [6] = '{3, 4, 3, 3, 3, 3};
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(mk("b2b", seq_ins[i], 0, 0, 1'b1, seq_rw[i], 0, 0, 0, 0, 0, 0, seq_cyc[i], 0, 0));
            drive_instr(seq_ins[i], 0, 0, 1'b1, 1'b0);
            e = sb_q.pop_front();
            total++;
            if (o_first_pcen !== 1'b0 || o_first_regwen !== 1'b0) begin
                bad++; $display("FAIL b2b[%0d] pulse_stretch PCEn/RegWEN after WB got=%b/%b want=0/0", i, o_first_pcen, o_first_regwen);
            end
            total++;
            if (o_regwen_n !== int'(e.regwen)) begin
                bad++; $display("FAIL b2b[%0d] RegWEN_cycles got=%0d want=%0d", i, o_regwen_n, e.regwen);
            end
            total++;
            if (o_cycles !== e.cycles) begin bad++; $display("FAIL b2b[%0d] cycles got=%0d want=%0d", i, o_cycles, e.cycles); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.instr = 32'h8C22_0004; bus.ihit = 1'b1;
        @(negedge CLK);
        bus.ihit = 1'b0; bus.instr = 32'hDEAD_BEEF;
        @(negedge CLK);
        total++;
        if (bus.dmemREN !== 1'b1) begin bad++; $display("FAIL midreset_pre dmemREN got=%b want=1", bus.dmemREN); end
        #2 nRST = 1'b0;
        #1;
        total++;
        if ({bus.dmemREN, bus.imemREN, bus.PCEn, bus.RegWEN} !== 4'b0 || bus.ir !== 32'h0) begin
            bad++; $display("FAIL midreset_drop dmemREN=%b imemREN=%b PCEn=%b RegWEN=%b ir=%h want all 0",
                bus.dmemREN, bus.imemREN, bus.PCEn, bus.RegWEN, bus.ir);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
    endtask

    task automatic test_timeout();
        logic acc;
        do_reset();
        drive_instr(32'h2402_0005, 99, 0, 1'b0, 1'b0);
        total++;
        if (o_fetch !== 15 || o_halt !== 1'b1 || o_wb !== 1'b0) begin
            bad++; $display("FAIL timeout_fetch fetch_cycles=%0d halt=%b wb=%b want 15/1/0", o_fetch, o_halt, o_wb);
        end
        total++;
        if (bus.timeout !== 1'b1 || bus.imemREN !== 1'b0) begin
            bad++; $display("FAIL timeout_flag timeout=%b imemREN=%b want 1/0", bus.timeout, bus.imemREN);
        end
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.ihit = 1'b1; bus.instr = 32'h2402_0005;
            @(negedge CLK);
            acc = acc | bus.imemREN | ~bus.halt | ~bus.timeout;
        end
        bus.ihit = 1'b0;
        total++;
        if (acc !== 1'b0) begin bad++; $display("FAIL timeout_sticky got=%b want=0", acc); end
        do_reset();
        total++;
        if (bus.timeout !== 1'b0 || bus.halt !== 1'b0) begin
            bad++; $display("FAIL timeout_clear timeout=%b halt=%b want 0/0", bus.timeout, bus.halt);
        end
        drive_instr(32'h2402_0005, 14, 0, 1'b0, 1'b0);
        total++;
        if (o_wb !== 1'b1 || o_fetch !== 15 || o_cycles !== 17 || bus.timeout !== 1'b0) begin
            bad++; $display("FAIL timeout_hit_wins wb=%b fetch=%0d cycles=%0d timeout=%b want 1/15/17/0",
                o_wb, o_fetch, o_cycles, bus.timeout);
        end
    endtask

    task automatic test_halt();
        logic acc;
        do_reset();
        drive_instr(32'hFC00_0000, 0, 0, 1'b0, 1'b0);
        total++;
        if (o_halt !== 1'b1 || o_cycles !== 3 || o_wb !== 1'b0 || bus.timeout !== 1'b0) begin
            bad++; $display("FAIL halt_entry halt=%b cycles=%0d wb=%b timeout=%b want 1/3/0/0",
                o_halt, o_cycles, o_wb, bus.timeout);
        end
        acc = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.ihit = 1'b1; bus.dhit = 1'b1; bus.instr = 32'h2402_0005;
            @(negedge CLK);
            acc = acc | bus.imemREN | bus.dmemREN | bus.dmemWEN | bus.PCEn | bus.RegWEN | ~bus.halt;
        end
        bus.ihit = 1'b0; bus.dhit = 1'b0;
        total++;
        if (acc !== 1'b0) begin bad++; $display("FAIL halt_sticky got=%b want=0", acc); end
        #2 nRST = 1'b0;
        #1;
        total++;
        if (bus.halt !== 1'b0 || bus.imemREN !== 1'b0) begin
            bad++; $display("FAIL halt_reset halt=%b imemREN=%b want 0/0", bus.halt, bus.imemREN);
        end
        @(negedge CLK);
        nRST = 1'b1;
        #1;
        total++;
        if (bus.imemREN !== 1'b1) begin bad++; $display("FAIL halt_refetch imemREN got=%b want=1", bus.imemREN); end
    endtask

    task automatic test_ovf();
        exp_t e;
        do_reset();
`ifdef OVF_TRAP_EN
        sb_q.push_back(mk("ovf_trap", 32'h0022_1820, 0, 0, 1'b0, 0, 0, 0, 1, 0, 0, 0, 3, 0, 0));
`else
        sb_q.push_back(mk("ovf_pass", 32'h0022_1820, 0, 0, 1'b0, 1, 0, 0, 1, 0, 0, 0, 3, 0, 0));
`endif
        drive_instr(32'h0022_1820, 0, 0, 1'b0, 1'b1);
        e = sb_q.pop_front();
        total++;
        if (o_regwen_n !== int'(e.regwen)) begin
            bad++; $display("FAIL %s RegWEN_cycles got=%0d want=%0d", e.nm, o_regwen_n, e.regwen);
        end
        total++;
        if (o_wb !== e.regwen || o_halt !== ~e.regwen || o_cycles !== e.cycles) begin
            bad++; $display("FAIL %s PCEn=%b halt=%b cycles=%0d want %b/%b/%0d",
                e.nm, o_wb, o_halt, o_cycles, e.regwen, ~e.regwen, e.cycles);
        end
        bus.overflow = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode_table();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_halt();
        test_ovf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
